// File: rtl/sbox_word_unit_if.sv
// sbox_word_unit_if: valid/ready bus of the multi-byte S-box unit.
// The input side carries the word and the forward/inverse select; the output
// side carries the substituted word. busy reports that a word is in flight.
interface sbox_word_unit_if #(
   parameter int NBYTES = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   in_data;
   logic                  in_inv;
   logic                  out_valid;
   logic                  out_ready;
   logic [8*NBYTES-1:0]   out_data;
   logic                  busy;

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/sbox_word_unit.sv
// sbox_word_unit: AES SubBytes / SubWord engine.
// A word of NBYTES bytes is accepted in IDLE, substituted LANES bytes per
// cycle in BUSY (lowest chunk first, in place in the work register) and
// presented in DONE until the consumer takes it.
// Each lane computes the S-box algebraically (GF(2^8) inverse plus affine
// map), so no ROM is needed and the lane stays purely combinational.
// Optional macro SBOX_INV_EN: builds the inverse S-box into every lane and
// lets in_inv select InvSubBytes; without it every word uses the forward box.
module sbox_word_unit #(
   parameter int NBYTES = 16,
   parameter int LANES  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   sbox_word_unit_if.slave bus
);
   localparam int NCHUNK = (LANES > 0) ? (NBYTES / LANES) : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int WW     = 8 * NBYTES;
   localparam int BW     = (WW > 1) ? $clog2(WW) : 1;

   // Configuration sanity: lanes must tile the word, and the bus must match.
   if (LANES < 1 || (NBYTES % LANES) != 0) begin : g_bad_lanes
      $error("sbox_word_unit: LANES must divide NBYTES");
   end
   if ($bits(bus.in_data) != WW) begin : g_bad_bus
      $error("sbox_word_unit: interface NBYTES differs from unit NBYTES");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // GF(2^8) helpers, AES polynomial x^8 + x^4 + x^3 + x + 1
   // ---------------------------------------------------------------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (aa & {8{b[i]}});
         aa = {aa[6:0], 1'b0} ^ (8'h1B & {8{aa[7]}});
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      return affine_fwd(gf_inv(x));
   endfunction

`ifdef SBOX_INV_EN
   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return gf_inv(affine_inv(x));
   endfunction
`endif

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t          state_r;
   state_t          next_state_s;
   logic [CW-1:0]   cnt_r;
   logic [WW-1:0]   work_r;
   logic [WW-1:0]   work_next_s;
   logic [BW-1:0]   base_bit_s;
   logic            last_chunk_s;
   logic            out_valid_r;
   logic            in_ready_r;
   logic            busy_r;
   logic [WW-1:0]   out_data_r;
   logic [7:0]      lane_in_s  [LANES];
   logic [7:0]      lane_out_s [LANES];

   assign last_chunk_s = (cnt_r == CW'(NCHUNK - 1));
   assign base_bit_s   = BW'(32'(cnt_r) * 32'(8 * LANES));

`ifdef SBOX_INV_EN
   logic mode_r;

   // Word mode: captured with the word, frozen until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= 1'b0;
      end else if (state_r == ST_IDLE && bus.in_valid) begin
         mode_r <= bus.in_inv;
      end else begin
         mode_r <= mode_r;
      end
   end
`else
   // Port kept for interface stability; the forward box is the only choice.
   logic unused_inv_s;
   assign unused_inv_s = bus.in_inv;
`endif

   // Lanes: each substitutes one byte of the current chunk.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_in_s[l] = work_r[base_bit_s + BW'(8 * l) +: 8];
`ifdef SBOX_INV_EN
      assign lane_out_s[l] = mode_r ? sbox_inv(lane_in_s[l]) : sbox_fwd(lane_in_s[l]);
`else
      assign lane_out_s[l] = sbox_fwd(lane_in_s[l]);
`endif
   end

   // Work register image after this cycle's chunk is written back in place.
   always_comb begin
      work_next_s = work_r;
      if (state_r == ST_BUSY) begin
         for (int l = 0; l < LANES; l++) begin
            work_next_s[base_bit_s + BW'(8 * l) +: 8] = lane_out_s[l];
         end
      end else begin
         work_next_s = work_r;
      end
   end

   // Next-state logic: accept in IDLE, walk the chunks, wait for the consumer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) next_state_s = ST_BUSY;
            else              next_state_s = ST_IDLE;
         end
         ST_BUSY: begin
            if (last_chunk_s) next_state_s = ST_DONE;
            else              next_state_s = ST_BUSY;
         end
         ST_DONE: begin
            if (bus.out_ready) next_state_s = ST_IDLE;
            else               next_state_s = ST_DONE;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= next_state_s;
   end

   // Work register and chunk counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_r <= {WW{1'b0}};
         cnt_r  <= {CW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  work_r <= bus.in_data;
                  cnt_r  <= {CW{1'b0}};
               end else begin
                  work_r <= work_r;
                  cnt_r  <= cnt_r;
               end
            end
            ST_BUSY: begin
               work_r <= work_next_s;
               if (last_chunk_s) cnt_r <= {CW{1'b0}};
               else              cnt_r <= cnt_r + CW'(1);
            end
            default: begin
               work_r <= work_r;
               cnt_r  <= cnt_r;
            end
         endcase
      end
   end

   // Registered outputs, decoded from the next state only (no out_ready to
   // in_ready path); the result register holds until the next word finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         out_data_r  <= {WW{1'b0}};
      end else begin
         out_valid_r <= (next_state_s == ST_DONE);
         in_ready_r  <= (next_state_s == ST_IDLE);
         busy_r      <= (next_state_s != ST_IDLE);
         if (state_r == ST_BUSY && last_chunk_s) out_data_r <= work_next_s;
         else                                    out_data_r <= out_data_r;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sbox_word_unit.sv
// tb_sbox_word_unit: three instances (16B/4 lanes, 4B/2 lanes, 16B/16 lanes)
// driven in lockstep and compared against a table-lookup model built from
// the published FIPS-197 S-box; the inverse box is derived by inverting it.
module tb_sbox_word_unit;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sbox_word_unit_if #(.NBYTES(16)) ifa ();
   sbox_word_unit_if #(.NBYTES(4))  ifb ();
   sbox_word_unit_if #(.NBYTES(16)) ifc ();

   sbox_word_unit #(.NBYTES(16), .LANES(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   sbox_word_unit #(.NBYTES(4),  .LANES(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   sbox_word_unit #(.NBYTES(16), .LANES(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

`ifdef SBOX_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   localparam logic [7:0] FWD [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic [7:0] inv_tab [256];
   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [127:0] data;
      logic         inv;
      logic [127:0] exp16;
      logic [31:0]  exp4;
   } vec_t;

   vec_t tab [3];

   // Reference: per-byte table lookup over the first n bytes.
   function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int n);
      logic [127:0] r;
      logic [7:0]   b;
      r = 128'h0;
      for (int i = 0; i < n; i++) begin
         b = d[8*i +: 8];
         r[8*i +: 8] = (inv && INV_EN) ? inv_tab[b] : FWD[b];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one word to all three units, measure latency, collect results,
   // then release them together. Inputs are scrambled while the units work.
   task automatic drive_word(input logic [127:0] d, input logic inv,
                             output logic [127:0] ra, output logic [31:0] rb,
                             output logic [127:0] rc,
                             output int la, output int lb, output int lc);
      ifa.in_valid = 1'b1; ifa.in_data = d;        ifa.in_inv = inv;
      ifb.in_valid = 1'b1; ifb.in_data = d[31:0];  ifb.in_inv = inv;
      ifc.in_valid = 1'b1; ifc.in_data = d;        ifc.in_inv = inv;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0; ifa.in_data = ~d;       ifa.in_inv = ~inv;
      ifb.in_valid = 1'b0; ifb.in_data = ~d[31:0]; ifb.in_inv = ~inv;
      ifc.in_valid = 1'b0; ifc.in_data = ~d;       ifc.in_inv = ~inv;
      la = -1; lb = -1; lc = -1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk); #1;
         if (ifa.out_valid && la < 0) la = cyc;
         if (ifb.out_valid && lb < 0) lb = cyc;
         if (ifc.out_valid && lc < 0) lc = cyc;
         if (la >= 0 && lb >= 0 && lc >= 0) break;
      end
      ra = ifa.out_data;
      rb = ifb.out_data;
      rc = ifc.out_data;
      ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; ifc.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.out_ready = 1'b0; ifb.out_ready = 1'b0; ifc.out_ready = 1'b0;
      check("a_release_out_valid", 128'(ifa.out_valid), 128'h0);
      check("a_release_in_ready",  128'(ifa.in_ready),  128'h1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [127:0] d, ra, rc, exp16, exp_b;
      logic [31:0]  rb;
      logic         inv;
      int           la, lb, lc, waited;

      for (int x = 0; x < 256; x++) inv_tab[FWD[x]] = 8'(x);

      tab[0] = '{data: 128'h0, inv: 1'b0, exp16: {16{8'h63}}, exp4: 32'h63636363};
      tab[1] = '{data: {96'h0, 32'h1001FF53}, inv: 1'b0,
                 exp16: {{12{8'h63}}, 32'hCA7C16ED}, exp4: 32'hCA7C16ED};
`ifdef SBOX_INV_EN
      tab[2] = '{data: {96'h0, 32'h7C16ED63}, inv: 1'b1,
                 exp16: {{12{8'h52}}, 32'h01FF5300}, exp4: 32'h01FF5300};
`else
      tab[2] = '{data: {96'h0, 32'h7C16ED63}, inv: 1'b1,
                 exp16: {{12{8'h63}}, 32'h104755FB}, exp4: 32'h104755FB};
`endif

      rst_n = 1'b0;
      ifa.in_valid = 1'b0; ifa.in_data = 128'h0; ifa.in_inv = 1'b0; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_data = 32'h0;  ifb.in_inv = 1'b0; ifb.out_ready = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_data = 128'h0; ifc.in_inv = 1'b0; ifc.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  128'(ifa.in_ready),  128'h1);
      check("rst_out_valid", 128'(ifa.out_valid), 128'h0);
      check("rst_busy",      128'(ifa.busy),      128'h0);
      check("rst_out_data",  ifa.out_data,        128'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table
      for (int t = 0; t < 3; t++) begin
         drive_word(tab[t].data, tab[t].inv, ra, rb, rc, la, lb, lc);
         check("tab_a_data", ra, tab[t].exp16);
         check("tab_b_data", {96'h0, rb}, {96'h0, tab[t].exp4});
         check("tab_c_data", rc, tab[t].exp16);
         check("tab_a_latency", 128'(la), 128'd4);
         check("tab_b_latency", 128'(lb), 128'd2);
         check("tab_c_latency", 128'(lc), 128'd1);
      end

      // Random words, random mode
      for (int r = 0; r < 16; r++) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         drive_word(d, inv, ra, rb, rc, la, lb, lc);
         exp16 = model(d, inv, 16);
         exp_b = model(d, inv, 4);
         check("rnd_a_data", ra, exp16);
         check("rnd_b_data", {96'h0, rb}, {96'h0, exp_b[31:0]});
         check("rnd_c_data", rc, exp16);
         check("rnd_a_latency", 128'(la), 128'd4);
      end

      // Every byte value through the single-cycle unit, both modes
      for (int m = 0; m < 2; m++) begin
         for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(w * 16 + i);
            drive_word(d, 1'(m), ra, rb, rc, la, lb, lc);
            check("sweep_c_data", rc, model(d, 1'(m), 16));
            check("sweep_c_latency", 128'(lc), 128'd1);
         end
      end

      // Backpressure: hold DONE for 6 cycles with a stray in_valid pulse
      d = {$urandom, $urandom, $urandom, $urandom};
      exp16 = model(d, 1'b0, 16);
      ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_inv = 1'b0;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      waited = 0;
      while (!ifa.out_valid && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("bp_reached_done", 128'(ifa.out_valid), 128'h1);
      for (int k = 0; k < 6; k++) begin
         check("bp_out_valid", 128'(ifa.out_valid), 128'h1);
         check("bp_out_data",  ifa.out_data,        exp16);
         check("bp_in_ready",  128'(ifa.in_ready),  128'h0);
         ifa.in_valid = (k == 2);
         ifa.in_data  = ~d;
         @(posedge clk); #1;
      end
      ifa.in_valid  = 1'b0;
      ifa.out_ready = 1'b1;
      @(posedge clk); #1;
      ifa.out_ready = 1'b0;
      check("bp_rel_in_ready",  128'(ifa.in_ready),  128'h1);
      check("bp_rel_out_valid", 128'(ifa.out_valid), 128'h0);
      check("bp_rel_busy",      128'(ifa.busy),      128'h0);
      check("bp_retained_data", ifa.out_data,        exp16);
      repeat (6) @(posedge clk);
      #1;
      check("bp_no_second_accept", 128'({ifa.out_valid, ifa.busy}), 128'h0);

      // Reset while the third chunk is being processed
      d = {$urandom, $urandom, $urandom, $urandom};
      ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_inv = 1'b0;
      @(posedge clk); #1;
      ifa.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mid_busy_before", 128'(ifa.busy), 128'h1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 128'(ifa.out_valid), 128'h0);
      check("rst_mid_in_ready",  128'(ifa.in_ready),  128'h1);
      check("rst_mid_busy",      128'(ifa.busy),      128'h0);
      check("rst_mid_out_data",  ifa.out_data,        128'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      d = {$urandom, $urandom, $urandom, $urandom};
      drive_word(d, 1'b0, ra, rb, rc, la, lb, lc);
      check("post_rst_a_data", ra, model(d, 1'b0, 16));
      check("post_rst_a_latency", 128'(la), 128'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/sbox_word_unit.md
Name: sbox_word_unit

Overview:
Multi-byte AES SubBytes engine for the encryption/decryption datapath. It accepts a word of NBYTES bytes over a valid/ready handshake and substitutes every byte through the FIPS-197 S-box. It uses LANES byte-substitution lanes per cycle, so one word takes NBYTES/LANES cycles. The result is held on a valid/ready output until consumed, so one instance serves as a 16-byte state SubBytes step or a 4-byte key-schedule SubWord step.

Parameters:
NBYTES  16  bytes per word; 4 for key-schedule SubWord, 16 for full state.
LANES   4   S-box lanes evaluated per cycle; must divide NBYTES, else elaboration error.

Ports:
clk        input   1          rising-edge clock
rst_n      input   1          asynchronous active-low reset
in_valid   input   1          input word valid
in_ready   output  1          unit can accept a word
in_data    input   8*NBYTES   input word; byte i = bits [8i+7:8i]
in_inv     input   1          0 = forward S-box, 1 = inverse S-box
out_valid  output  1          result word valid
out_ready  input   1          downstream accepts result
out_data   output  8*NBYTES   substituted word, same byte ordering
busy       output  1          high in BUSY or DONE

Behaviour:
- Reset (async assert, sync deassert by the integrator): state=IDLE, chunk counter=0, out_valid=0, out_data=0, busy=0, in_ready=1. Reset mid-operation aborts the word; nothing is emitted.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid=1, the unit latches in_data into the work register and latches in_inv as the word mode, sets counter=0, and goes to BUSY.
- BUSY: in_ready=0. Each cycle it substitutes bytes [counter*LANES .. counter*LANES+LANES-1] of the work register in place, lowest chunk first. Forward or inverse S-box is selected by the latched mode. The counter increments each cycle. After the chunk with counter = NBYTES/LANES-1, it goes to DONE.
- DONE: out_valid=1, out_data = work register, stable while out_ready=0. On out_ready=1 it goes to IDLE and out_valid drops the next cycle.
- Latency: with the accept edge at cycle 0, out_valid=1 after cycle NBYTES/LANES. Throughput is one word per NBYTES/LANES+2 cycles.
- in_ready is driven only from state, with no combinational path from out_ready.
- in_data and in_inv changes while not in IDLE are ignored; the mode cannot change mid-word.
- Counter width is clog2(NBYTES/LANES), minimum 1. When LANES=NBYTES, BUSY lasts exactly one cycle.
- Each S-box lane is purely combinational; the lane outputs are registered in the work register.
- out_data retains the last result after leaving DONE, until the next word overwrites it.

Optional Feature:
Macro SBOX_INV_EN.
- Defined: the inverse S-box table is compiled into every lane, and in_inv=1 selects InvSubBytes.
- Undefined: no inverse table is built and in_inv is ignored; every word uses the forward S-box. The in_inv port remains present for interface stability.

Test Plan:
- NBYTES=16, LANES=4, in_data=all 0x00, in_inv=0 -> out_data=all 0x63; out_valid asserts exactly 4 cycles after accept.
- Known bytes: bytes 0..3 = 0x53,0xFF,0x01,0x10 in a 4-byte word, forward -> 0xED,0x16,0x7C,0xCA.
- With SBOX_INV_EN, in_inv=1, bytes 0x63,0xED,0x16,0x7C -> 0x00,0x53,0xFF,0x01. Without the macro, the same stimulus -> 0xFB,0x55,0x47,0x10.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_data and out_valid stable, in_ready=0, a second in_valid pulse is not accepted. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Reset: assert rst_n=0 during BUSY at chunk 2 -> out_valid=0 and in_ready=1 immediately. After release, a fresh word completes normally with no stale bytes.
- LANES=NBYTES=16, all 256 byte values streamed 16 per word -> every byte matches the FIPS-197 table, latency 1 cycle.
